// File: rtl/alu_wide_pkg.sv
// alu_wide_pkg: opcode, flag-index and flag-mode encodings plus flag helpers for alu_wide.
// Define ALU_WIDE_SHL_EN to enable the SL/RL shift opcodes.
package alu_wide_pkg;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP,
    ALU_INC, ALU_DEC, ALU_SL, ALU_RL, ALU_PASS0, ALU_PASS1, ALU_SWAP
  } alu_op_e;
  typedef enum int {FLAG_C, FLAG_H, FLAG_N, FLAG_Z} flag_idx_e;
  typedef enum logic {ALU_FLAGMODE_FULL, ALU_FLAGMODE_ADDR} flag_mode_e;
  function automatic logic is_shl(input logic [4:0] op);
`ifdef ALU_WIDE_SHL_EN
    return op == ALU_SL || op == ALU_RL;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic is_sub(input logic [4:0] op);
    return op == ALU_SUB || op == ALU_SBC || op == ALU_DEC;
  endfunction
  function automatic logic is_arith(input logic [4:0] op);
    return is_sub(op) || op == ALU_ADD || op == ALU_ADC || op == ALU_INC;
  endfunction
  function automatic logic [3:0] znhc(input logic z, n, h, c);
    logic [3:0] f;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_H] = h;
    f[FLAG_C] = c;
    return f;
  endfunction
  // Final flags once the last slice is known; fin is the flags word latched at start.
  function automatic logic [3:0] wide_flags(input logic [4:0] op, input logic mode,
                                            input logic [3:0] fin, input logic z, h, c);
    logic addr;
    addr = mode == ALU_FLAGMODE_ADDR;
    if (is_shl(op)) return znhc(z, 1'b0, 1'b0, c);
    case (op)
      ALU_ADD, ALU_ADC: return znhc(addr ? fin[FLAG_Z] : z, 1'b0, h, c);
      ALU_SUB, ALU_SBC: return znhc(z, 1'b1, h, c);
      ALU_INC, ALU_DEC: return addr ? fin : znhc(z, op == ALU_DEC, h, fin[FLAG_C]);
      ALU_AND: return znhc(z, 1'b0, 1'b1, 1'b0);
      ALU_OR, ALU_XOR: return znhc(z, 1'b0, 1'b0, 1'b0);
      default: return fin;
    endcase
  endfunction
endpackage

// File: rtl/alu_wide_slice.sv
// alu_slice: combinational 8-bit slice of alu_wide; a is the first operand byte, b the second.
module alu_slice
  import alu_wide_pkg::*;
(
  input  logic [4:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] res,
  output logic       cout,
  output logic       hc
);
  logic sub, arith;
  logic [7:0] bb;
  logic [8:0] s9;
  logic [4:0] h5;
  always_comb begin
    sub = is_sub(op);
    arith = is_arith(op);
    bb = (op == ALU_INC || op == ALU_DEC) ? 8'h00 : b;
    s9 = sub ? {1'b0, a} - {1'b0, bb} - {8'b0, cin} : {1'b0, a} + {1'b0, bb} + {8'b0, cin};
    h5 = sub ? {1'b0, a[3:0]} - {1'b0, bb[3:0]} - {4'b0, cin}
             : {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'b0, cin};
    res = arith ? s9[7:0] :
          op == ALU_AND ? a & b :
          op == ALU_OR ? a | b :
          op == ALU_XOR ? a ^ b :
          is_shl(op) ? {a[6:0], cin} :
          op == ALU_PASS1 ? a : b;
    cout = arith ? s9[8] : is_shl(op) & a[7];
    hc = arith & h5[4];
  end
endmodule

// File: rtl/alu_wide.sv
// alu_wide: multi-cycle WIDTH-bit ALU, one byte slice per clock LSB first, ZNHC flags.
// Define ALU_WIDE_SHL_EN to add the SL/RL shift opcodes.
module alu_wide
  import alu_wide_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int NSLICE = WIDTH / 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alu_start,
  output logic             alu_ready,
  output logic             alu_done,
  input  logic [4:0]       alu_op,
  input  logic             alu_flag_mode,
  input  logic [WIDTH-1:0] alu_data0_in,
  input  logic [WIDTH-1:0] alu_data1_in,
  input  logic [3:0]       alu_flags_in,
  output logic [WIDTH-1:0] alu_data_out,
  output logic [3:0]       alu_flags_out
);
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, zero_q, zero_d, mode_q, mode_d;
  logic [4:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, data_q, data_d;
  logic [3:0] fin_q, fin_d, flags_q, flags_d;
  logic [7:0] s_res;
  logic s_cout, s_hc, z;
  alu_slice u_slice (
    .op  (op_q),
    .a   (a_q[{idx_q, 3'b000} +: 8]),
    .b   (b_q[{idx_q, 3'b000} +: 8]),
    .cin (carry_q),
    .res (s_res),
    .cout(s_cout),
    .hc  (s_hc)
  );
  assign alu_ready = state_q != RUN;
  assign alu_done = state_q == DONE;
  assign alu_data_out = data_q;
  assign alu_flags_out = flags_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    carry_d = carry_q;
    zero_d = zero_q;
    mode_d = mode_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    data_d = data_q;
    fin_d = fin_q;
    flags_d = flags_q;
    z = zero_q & (s_res == 8'h00);
    if (alu_start && state_q != RUN) begin
      state_d = RUN;
      idx_d = '0;
      zero_d = 1'b1;
      op_d = alu_op;
      mode_d = alu_flag_mode;
      a_d = alu_data1_in;
      b_d = alu_data0_in;
      fin_d = alu_flags_in;
      carry_d = (alu_op == ALU_ADC || alu_op == ALU_SBC || (is_shl(alu_op) && alu_op == ALU_RL))
                ? alu_flags_in[FLAG_C] : (alu_op == ALU_INC || alu_op == ALU_DEC);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    if (state_q == RUN) begin
      res_d[{idx_q, 3'b000} +: 8] = s_res;
      carry_d = s_cout;
      zero_d = z;
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(NSLICE - 1)) begin
        state_d = DONE;
        data_d = res_d;
        flags_d = wide_flags(op_q, mode_q, fin_q, z, s_hc, s_cout);
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      mode_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      data_q <= '0;
      fin_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      mode_q <= mode_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      data_q <= data_d;
      fin_q <= fin_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_alu_wide.sv
// tb_alu_wide: table-driven scoreboard bench for alu_wide at WIDTH=16.
module tb_alu_wide;
  import alu_wide_pkg::*;
  localparam int W = 16;
  typedef struct {
    logic [4:0]   op;
    logic         mode;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [3:0]   fin;
    logic [W-1:0] ed;
    logic [3:0]   ef;
  } vec_t;
  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   f;
    string        name;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, mode = 0;
  logic [4:0] op = 0;
  logic [W-1:0] d0 = 0, d1 = 0;
  logic [3:0] fin = 0;
  logic ready, done;
  logic [W-1:0] dout;
  logic [3:0] fout;
  exp_t sb[$];
  exp_t e_m;
  vec_t tv[$];
  int n_vec = 0, n_bad = 0, n_done = 0;

  alu_wide #(.WIDTH(W)) dut (
    .clock(clk), .reset_n(rst_n), .alu_start(start), .alu_ready(ready), .alu_done(done),
    .alu_op(op), .alu_flag_mode(mode), .alu_data0_in(d0), .alu_data1_in(d1),
    .alu_flags_in(fin), .alu_data_out(dout), .alu_flags_out(fout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: done pulse with data=%h flags=%b, required no pulse", dout, fout);
      end else begin
        e_m = sb.pop_front();
        if (dout !== e_m.d || fout !== e_m.f) begin
          n_bad++;
          $display("FAIL %s: data=%h flags=%b, required data=%h flags=%b", e_m.name, dout, fout, e_m.d, e_m.f);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic issue(input vec_t v, input string nm);
    op = v.op; mode = v.mode; d0 = v.d0; d1 = v.d1; fin = v.fin; start = 1;
    sb.push_back('{v.ed, v.ef, nm});
  endtask

  task automatic wait_done(input string nm, input int lat0);
    int lat = lat0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd3);
    if (!done) sb.delete();
  endtask

  task automatic run(input vec_t v, input string nm);
    issue(v, nm);
    @(negedge clk);
    start = 0;
    op = 5'($urandom); d0 = W'($urandom); d1 = W'($urandom); fin = 4'($urandom); mode = 1'($urandom);
    wait_done(nm, 1);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    tv.push_back('{ALU_ADD,   1'b0, 16'h0001, 16'h0FFF, 4'b0000, 16'h1000, 4'b0010});
    tv.push_back('{ALU_SUB,   1'b0, 16'h0001, 16'h0000, 4'b0000, 16'hFFFF, 4'b0111});
    tv.push_back('{ALU_SUB,   1'b0, 16'h1234, 16'h1234, 4'b0000, 16'h0000, 4'b1100});
    tv.push_back('{ALU_INC,   1'b1, 16'h0000, 16'hFFFF, 4'b0101, 16'h0000, 4'b0101});
    tv.push_back('{ALU_INC,   1'b0, 16'h0000, 16'hFFFF, 4'b0101, 16'h0000, 4'b1011});
    tv.push_back('{ALU_ADC,   1'b0, 16'h0000, 16'h00FF, 4'b0001, 16'h0100, 4'b0000});
    tv.push_back('{ALU_SBC,   1'b0, 16'h0000, 16'h1000, 4'b0001, 16'h0FFF, 4'b0110});
    tv.push_back('{ALU_DEC,   1'b0, 16'h0000, 16'h0000, 4'b0000, 16'hFFFF, 4'b0110});
    tv.push_back('{ALU_AND,   1'b0, 16'h0FF0, 16'hF0F0, 4'b0000, 16'h00F0, 4'b0010});
    tv.push_back('{ALU_AND,   1'b0, 16'h00FF, 16'hFF00, 4'b0001, 16'h0000, 4'b1010});
    tv.push_back('{ALU_OR,    1'b0, 16'h0034, 16'h1200, 4'b1111, 16'h1234, 4'b0000});
    tv.push_back('{ALU_XOR,   1'b0, 16'hA5A5, 16'hA5A5, 4'b0000, 16'h0000, 4'b1000});
    tv.push_back('{ALU_PASS0, 1'b0, 16'hBEEF, 16'h1234, 4'b1010, 16'hBEEF, 4'b1010});
    tv.push_back('{ALU_PASS1, 1'b0, 16'hBEEF, 16'h1234, 4'b1010, 16'h1234, 4'b1010});
    tv.push_back('{ALU_ADD,   1'b1, 16'h8000, 16'h8000, 4'b1000, 16'h0000, 4'b1001});
    tv.push_back('{ALU_ADD,   1'b0, 16'h0001, 16'hFFFF, 4'b0000, 16'h0000, 4'b1011});
    tv.push_back('{ALU_CP,    1'b0, 16'h5555, 16'hAAAA, 4'b0110, 16'h5555, 4'b0110});
`ifdef ALU_WIDE_SHL_EN
    tv.push_back('{ALU_RL,    1'b0, 16'h8001, 16'h8001, 4'b0001, 16'h0003, 4'b0001});
    tv.push_back('{ALU_SL,    1'b0, 16'h4000, 16'h4000, 4'b0001, 16'h8000, 4'b0000});
`else
    tv.push_back('{ALU_RL,    1'b0, 16'h8001, 16'h8001, 4'b0001, 16'h8001, 4'b0001});
    tv.push_back('{ALU_SL,    1'b0, 16'h4000, 16'h4000, 4'b0001, 16'h4000, 4'b0001});
`endif
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_data", 32'(dout), 32'd0);
    chk("reset_flags", 32'(fout), 32'd0);
    rst_n = 1;
    @(negedge clk);
    foreach (tv[i]) run(tv[i], $sformatf("vec%0d", i));

    // start held high through RUN must be accepted only once
    n0 = n_done;
    issue(tv[0], "hold_start");
    @(negedge clk);
    chk("hold_ready_in_run", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    chk("hold_single_done", 32'(n_done - n0), 32'd1);

    // back-to-back: second start issued in the DONE cycle
    issue(tv[1], "b2b_first");
    @(negedge clk);
    start = 0;
    wait_done("b2b_first", 1);
    issue(tv[2], "b2b_second");
    @(negedge clk);
    start = 0;
    d0 = 16'hDEAD; d1 = 16'hBEEF;
    chk("b2b_data_held", 32'(dout), 32'h0000FFFF);
    wait_done("b2b_second", 1);
    @(negedge clk);

    // reset in the second RUN cycle aborts without a done pulse
    n0 = n_done;
    op = ALU_ADD; mode = 0; d0 = 16'h1111; d1 = 16'h2222; fin = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_data", 32'(dout), 32'd0);
    chk("abort_flags", 32'(fout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(n_done - n0), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
